// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Purpose  : Shares the register file's single write port between two
//            writeback sources. Each source feeds a private FIFO through a
//            valid/ready handshake; a round-robin arbiter drains one entry
//            per cycle into registered we3/a3/wd3, and a busy scoreboard
//            flags registers with pending writes.
// Options  : RF_ARB_STATS_EN adds a saturating contention counter output
//            (conflict_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s0_valid,
  output logic               s0_ready,
  input  logic [AW-1:0]      s0_addr,
  input  logic [DW-1:0]      s0_data,
  input  logic               s1_valid,
  output logic               s1_ready,
  input  logic [AW-1:0]      s1_addr,
  input  logic [DW-1:0]      s1_data,
  output logic               we3,
  output logic [AW-1:0]      a3,
  output logic [DW-1:0]      wd3,
  output logic [2**AW-1:0]   busy,
`ifdef RF_ARB_STATS_EN
  output logic [15:0]        conflict_cnt,
`endif
  output logic               idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int NR = 2**AW;

  // Per-source views, index 0 = source 0, index 1 = source 1
  logic [1:0]               w_valid;
  logic [1:0]               w_ready;
  logic [1:0]               w_push;
  logic [1:0]               w_pop;
  logic [1:0]               w_empty;
  logic [1:0]               w_full;
  logic [1:0][AW-1:0]       w_in_addr;
  logic [1:0][DW-1:0]       w_in_data;
  logic [1:0][AW-1:0]       w_head_addr;
  logic [1:0][DW-1:0]       w_head_data;
  logic                     w_contend;

  // r_run holds ready low until the first edge that samples rst_n high
  logic                     r_run;
  logic                     r_rr;

  assign w_valid   = {s1_valid, s0_valid};
  assign w_in_addr = {s1_addr, s0_addr};
  assign w_in_data = {s1_data, s0_data};
  assign s0_ready  = w_ready[0];
  assign s1_ready  = w_ready[1];

  generate
    for (genvar s = 0; s < 2; s++) begin : g_src
      logic [AW-1:0] r_mem_addr [DEPTH];
      logic [DW-1:0] r_mem_data [DEPTH];
      logic [PW:0]   r_wptr;
      logic [PW:0]   r_rptr;
      logic [PW:0]   w_cnt;
      logic [NR-1:0] w_busy_l;

      assign w_cnt          = r_wptr - r_rptr;
      assign w_empty[s]     = (r_wptr == r_rptr);
      assign w_full[s]      = (r_wptr[PW] != r_rptr[PW]) &&
                              (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
      // Ready depends only on registered state, never on valid
      assign w_ready[s]     = r_run && !w_full[s];
      // Writes to x0 complete the handshake but are dropped here
      assign w_push[s]      = w_valid[s] && w_ready[s] && (w_in_addr[s] != '0);
      assign w_head_addr[s] = r_mem_addr[r_rptr[PW-1:0]];
      assign w_head_data[s] = r_mem_data[r_rptr[PW-1:0]];

      // Pointer update; reset flushes the FIFO by equalising the pointers
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_wptr <= '0;
          r_rptr <= '0;
        end else begin
          if (w_push[s]) r_wptr <= r_wptr + 1'b1;
          if (w_pop[s])  r_rptr <= r_rptr + 1'b1;
        end
      end

      // Storage write; contents are meaningless once pointers are reset
      always_ff @(posedge clk) begin
        if (w_push[s]) begin
          r_mem_addr[r_wptr[PW-1:0]] <= w_in_addr[s];
          r_mem_data[r_wptr[PW-1:0]] <= w_in_data[s];
        end
      end

      // Mark destination registers of every occupied FIFO slot
      always_comb begin
        w_busy_l = '0;
        for (int i = 0; i < DEPTH; i++) begin
          if ({1'b0, PW'(i) - r_rptr[PW-1:0]} < w_cnt) begin
            w_busy_l[r_mem_addr[i]] = 1'b1;
          end
        end
      end
    end
  endgenerate

  // Grant selection: lone non-empty source wins, otherwise the RR pointer
  always_comb begin
    w_contend = !w_empty[0] && !w_empty[1];
    w_pop[0]  = !w_empty[0] && (w_empty[1] || !r_rr);
    w_pop[1]  = !w_empty[1] && (w_empty[0] ||  r_rr);
  end

  // Registered write port, RR pointer and ready enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_rr  <= 1'b0;
      we3   <= 1'b0;
      a3    <= '0;
      wd3   <= '0;
    end else begin
      r_run <= 1'b1;
      we3   <= |w_pop;
      if (w_pop[0]) begin
        a3  <= w_head_addr[0];
        wd3 <= w_head_data[0];
      end else if (w_pop[1]) begin
        a3  <= w_head_addr[1];
        wd3 <= w_head_data[1];
      end
      // Pointer moves only when both sources were competing
      if (w_contend) r_rr <= !r_rr;
    end
  end

  // Queued destinations plus the write currently on the port; x0 never busy
  assign busy = (g_src[0].w_busy_l | g_src[1].w_busy_l |
                 (we3 ? (NR'(1) << a3) : NR'(0))) & ~NR'(1);

  assign idle = (&w_empty) && !we3;

`ifdef RF_ARB_STATS_EN
  logic [15:0] r_conflict_cnt;

  // Saturating count of cycles where both FIFOs hold entries
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_contend && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_arbiter
// Purpose  : Self-checking bench for rf_write_arbiter. A queue-based
//            reference model tracks FIFO contents, grant order and the write
//            port; directed scenarios are followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

  localparam int DEPTH = 2;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 2**AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s0_valid, s1_valid;
  logic          s0_ready, s1_ready;
  logic [AW-1:0] s0_addr, s1_addr;
  logic [DW-1:0] s0_data, s1_data;
  logic          we3;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic [NR-1:0] busy;
  logic          idle;
`ifdef RF_ARB_STATS_EN
  logic [15:0]   conflict_cnt;
`endif

  always #5 clk = ~clk;

  rf_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s0_valid (s0_valid),
    .s0_ready (s0_ready),
    .s0_addr  (s0_addr),
    .s0_data  (s0_data),
    .s1_valid (s1_valid),
    .s1_ready (s1_ready),
    .s1_addr  (s1_addr),
    .s1_data  (s1_data),
    .we3      (we3),
    .a3       (a3),
    .wd3      (wd3),
    .busy     (busy),
`ifdef RF_ARB_STATS_EN
    .conflict_cnt (conflict_cnt),
`endif
    .idle     (idle)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Single comparison point: counts and reports mismatches
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef logic [AW+DW-1:0] ent_t;
  ent_t          q0[$];
  ent_t          q1[$];
  bit            m_run, m_rr, m_we;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  int            m_cnt;
  bit            acc0, acc1;
  logic [AW-1:0] wr_log[$];

  function automatic logic [NR-1:0] model_busy();
    logic [NR-1:0] b = '0;
    foreach (q0[i]) b[q0[i][AW+DW-1 -: AW]] = 1'b1;
    foreach (q1[i]) b[q1[i][AW+DW-1 -: AW]] = 1'b1;
    if (m_we) b[m_a] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  // Advance the model across one edge, then compare all outputs mid-cycle
  task automatic tick();
    bit   r0, r1, n0, n1;
    int   g;
    ent_t e;
    acc0 = 0;
    acc1 = 0;
    if (!rst_n) begin
      q0.delete(); q1.delete();
      m_run = 0; m_rr = 0; m_we = 0; m_a = '0; m_d = '0; m_cnt = 0;
    end else begin
      r0 = m_run && (q0.size() < DEPTH);
      r1 = m_run && (q1.size() < DEPTH);
      n0 = q0.size() > 0;
      n1 = q1.size() > 0;
      g  = -1;
      if (n0 && n1) begin
        g    = m_rr ? 1 : 0;
        m_rr = !m_rr;
        if (m_cnt < 65535) m_cnt++;
      end else if (n0) g = 0;
      else if (n1) g = 1;
      m_we = (g >= 0);
      if (g == 0) e = q0.pop_front();
      if (g == 1) e = q1.pop_front();
      if (g >= 0) begin
        m_a = e[AW+DW-1 -: AW];
        m_d = e[DW-1:0];
      end
      if (s0_valid && r0) begin
        acc0 = 1;
        if (s0_addr != '0) q0.push_back({s0_addr, s0_data});
      end
      if (s1_valid && r1) begin
        acc1 = 1;
        if (s1_addr != '0) q1.push_back({s1_addr, s1_data});
      end
      m_run = 1;
    end
    @(posedge clk);
    @(negedge clk);
    if (we3) wr_log.push_back(a3);
    check_eq("s0_ready", s0_ready, m_run && (q0.size() < DEPTH));
    check_eq("s1_ready", s1_ready, m_run && (q1.size() < DEPTH));
    check_eq("we3",      we3,  m_we);
    check_eq("a3",       a3,   m_a);
    check_eq("wd3",      wd3,  m_d);
    check_eq("busy",     busy, model_busy());
    check_eq("idle",     idle, (q0.size() == 0) && (q1.size() == 0) && !m_we);
`ifdef RF_ARB_STATS_EN
    check_eq("conflict_cnt", conflict_cnt, m_cnt);
`endif
  endtask

  // New source values only once the previous request has been taken
  task automatic drive_rand(input int pct_valid, input bit allow_x0);
    if (!s0_valid || acc0) begin
      s0_valid = ($urandom_range(0, 99) < pct_valid);
      s0_addr  = (allow_x0 && $urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, NR-1));
      s0_data  = $urandom;
    end
    if (!s1_valid || acc1) begin
      s1_valid = ($urandom_range(0, 99) < pct_valid);
      s1_addr  = (allow_x0 && $urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, NR-1));
      s1_data  = $urandom;
    end
  endtask

  initial begin
    bit seen_full;
    rst_n = 1'b0;
    s0_valid = 0; s0_addr = '0; s0_data = '0;
    s1_valid = 0; s1_addr = '0; s1_data = '0;
    @(negedge clk);

    // Reset state
    tick(); tick();
    check_eq("rst_idle",  idle, 1);
    check_eq("rst_busy",  busy, 0);
    check_eq("rst_rdy0",  s0_ready, 0);
    check_eq("rst_rdy1",  s1_ready, 0);
    rst_n = 1'b1;
    tick();
    check_eq("rdy_rise", s0_ready, 1);

    // Single write: latency and busy
    s0_valid = 1; s0_addr = 5; s0_data = 32'hDEADBEEF;
    tick();
    s0_valid = 0;
    check_eq("single_busy_q", busy[5], 1);
    tick();
    check_eq("single_we3", we3, 1);
    check_eq("single_a3",  a3, 5);
    check_eq("single_wd3", wd3, 32'hDEADBEEF);
    check_eq("single_busy_port", busy[5], 1);
    tick();
    check_eq("single_idle", idle, 1);

    // x0 drop
    s1_valid = 1; s1_addr = 0; s1_data = 32'h12345678;
    tick();
    s1_valid = 0;
    check_eq("x0_ready", s1_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("x0_we3",  we3, 0);
      check_eq("x0_busy", busy, 0);
    end

    // Contention ordering
    wr_log.delete();
    s0_valid = 1; s0_addr = 1; s0_data = 32'h1;
    s1_valid = 1; s1_addr = 3; s1_data = 32'h3;
    tick();
    s0_addr = 2; s0_data = 32'h2;
    s1_addr = 4; s1_data = 32'h4;
    tick();
    s0_valid = 0; s1_valid = 0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("order_len", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      check_eq("order_0", wr_log[0], 1);
      check_eq("order_1", wr_log[1], 3);
      check_eq("order_2", wr_log[2], 2);
      check_eq("order_3", wr_log[3], 4);
    end

    // Backpressure: both sources push every cycle, drain is one per cycle
    seen_full = 0;
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 12; i++) begin
      drive_rand(100, 0);
      tick();
      if (!s0_ready || !s1_ready) seen_full = 1;
    end
    s0_valid = 0; s1_valid = 0;
    for (int i = 0; i < 6; i++) tick();
    check_eq("full_seen",   seen_full, 1);
    check_eq("drain_idle",  idle, 1);

    // Mid-operation reset discards queued writes
    s0_valid = 1; s0_addr = 7; s0_data = 32'hA;
    s1_valid = 1; s1_addr = 9; s1_data = 32'hB;
    tick();
    s0_addr = 8; s1_addr = 10;
    tick();
    s0_valid = 0; s1_valid = 0;
    rst_n = 0;
    tick();
    check_eq("mrst_we3",  we3, 0);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_idle", idle, 1);
    rst_n = 1;
    wr_log.delete();
    for (int i = 0; i < 4; i++) tick();
    check_eq("mrst_nowr", wr_log.size(), 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive_rand(70, 1);
      tick();
    end
    rst_n = 1;

`ifdef RF_ARB_STATS_EN
    // Saturation of the contention counter
    s0_valid = 0; s1_valid = 0;
    rst_n = 0; tick(); rst_n = 1; tick();
    check_eq("cc_reset", conflict_cnt, 0);
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 70010; i++) begin
      drive_rand(100, 0);
      tick();
    end
    check_eq("cc_sat", conflict_cnt, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
